// File: rtl/ofdm_mapper.sv
// ----------------------------------------------------------------------------
// ofdm_mapper
//
// 802.11a constellation mapper. Interleaved coded bytes arrive on an
// AXI-Stream slave, are appended to a 16-bit bit buffer (bit 0 first in
// time), and are consumed from the LSB end in N-bit groups (BPSK 1, QPSK 2,
// 16-QAM 4, 64-QAM 6). Each group is Gray-mapped to one complex I/Q point and
// presented on the AXI-Stream master through a single output register.
//
// The modulation comes from RATE bits [3:2], latched from s_axis_tuser only
// when a byte is accepted into an empty buffer. RATE bits [1:0] are carried
// through on m_axis_tuser.
//
// Optional feature (macro MAPPER_NORM_EN):
//   defined   - each odd-integer level is multiplied by the Q1.14 K_MOD unit
//               step for the modulation (16384/11585/5181/2528), truncated to
//               IQ_WIDTH.
//   undefined - I and Q carry the raw levels -7..+7 sign-extended to IQ_WIDTH.
//
// Parameters:
//   IQ_WIDTH       width of each signed I / Q component
//
// Ports:
//   aclk           clock
//   aresetn        asynchronous active-low reset
//   s_axis_tdata   interleaved coded bits, bit 0 first in time
//   s_axis_tuser   RATE field {R1,R2,R3,R4}, R1 at bit 3
//   s_axis_tvalid  input valid
//   s_axis_tready  input ready (buffer holds 8 bits or fewer)
//   m_axis_tdata   {Q, I}, two's complement, I in the low half
//   m_axis_tuser   rate in force for this symbol
//   m_axis_tvalid  output valid
//   m_axis_tready  output ready
// ----------------------------------------------------------------------------
module ofdm_mapper #(
    parameter int IQ_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [7:0]            s_axis_tdata,
    input  logic [3:0]            s_axis_tuser,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [2*IQ_WIDTH-1:0] m_axis_tdata,
    output logic [3:0]            m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    // ------------------------------------------------------------------
    // Level mapping and scaling helpers
    // ------------------------------------------------------------------
    function automatic logic signed [3:0] lvl_1b(input logic b);
        return b ? 4'sd1 : -4'sd1;
    endfunction

    // code is {b0, b1}; b0 is the first bit in time
    function automatic logic signed [3:0] lvl_2b(input logic [1:0] code);
        logic signed [3:0] lvl;
        case (code)
            2'b00:   lvl = -4'sd3;
            2'b01:   lvl = -4'sd1;
            2'b11:   lvl =  4'sd1;
            default: lvl =  4'sd3;
        endcase
        return lvl;
    endfunction

    // code is {b0, b1, b2}; b0 is the first bit in time
    function automatic logic signed [3:0] lvl_3b(input logic [2:0] code);
        logic signed [3:0] lvl;
        case (code)
            3'b000:  lvl = -4'sd7;
            3'b001:  lvl = -4'sd5;
            3'b011:  lvl = -4'sd3;
            3'b010:  lvl = -4'sd1;
            3'b110:  lvl =  4'sd1;
            3'b111:  lvl =  4'sd3;
            3'b101:  lvl =  4'sd5;
            default: lvl =  4'sd7;
        endcase
        return lvl;
    endfunction

`ifdef MAPPER_NORM_EN
    localparam int PW = IQ_WIDTH + 16;

    // Constant multiply by the Q1.14 unit step; result truncated to IQ_WIDTH.
    function automatic logic signed [IQ_WIDTH-1:0] scale_level(
        input logic signed [3:0] lvl,
        input logic        [1:0] mod
    );
        logic signed [PW-1:0] unit;
        logic signed [PW-1:0] prod;
        case (mod)
            2'b11:   unit = PW'(16384);
            2'b01:   unit = PW'(11585);
            2'b10:   unit = PW'(5181);
            default: unit = PW'(2528);
        endcase
        prod = PW'(lvl) * unit;
        return prod[IQ_WIDTH-1:0];
    endfunction
`else
    function automatic logic signed [IQ_WIDTH-1:0] scale_level(
        input logic signed [3:0] lvl
    );
        return IQ_WIDTH'(lvl);
    endfunction
`endif

    // ------------------------------------------------------------------
    // Stage p0: bit buffer, count and latched rate
    // ------------------------------------------------------------------
    logic [15:0]       bits_p0;
    logic [4:0]        cnt_p0;
    logic [3:0]        rate_p0;
    logic [1:0]        mod_p0;
    logic [4:0]        nbits_p0;
    logic signed [3:0] lvl_i_p0;
    logic signed [3:0] lvl_q_p0;
    logic signed [IQ_WIDTH-1:0] sym_i_p0;
    logic signed [IQ_WIDTH-1:0] sym_q_p0;

    logic        accept;
    logic        load;
    logic [4:0]  cnt_left;
    logic [15:0] bits_left;
    logic [4:0]  cnt_next;
    logic [15:0] bits_next;

    // Stage p1: output register
    logic                  vld_p1;
    logic [2*IQ_WIDTH-1:0] data_p1;
    logic [3:0]            user_p1;

    assign mod_p0 = rate_p0[3:2];

    always_comb begin
        case (mod_p0)
            2'b11:   nbits_p0 = 5'd1;
            2'b01:   nbits_p0 = 5'd2;
            2'b10:   nbits_p0 = 5'd4;
            default: nbits_p0 = 5'd6;
        endcase
    end

    always_comb begin
        lvl_i_p0 = '0;
        lvl_q_p0 = '0;
        case (mod_p0)
            2'b11: begin
                lvl_i_p0 = lvl_1b(bits_p0[0]);
            end
            2'b01: begin
                lvl_i_p0 = lvl_1b(bits_p0[0]);
                lvl_q_p0 = lvl_1b(bits_p0[1]);
            end
            2'b10: begin
                lvl_i_p0 = lvl_2b({bits_p0[0], bits_p0[1]});
                lvl_q_p0 = lvl_2b({bits_p0[2], bits_p0[3]});
            end
            default: begin
                lvl_i_p0 = lvl_3b({bits_p0[0], bits_p0[1], bits_p0[2]});
                lvl_q_p0 = lvl_3b({bits_p0[3], bits_p0[4], bits_p0[5]});
            end
        endcase
    end

`ifdef MAPPER_NORM_EN
    assign sym_i_p0 = scale_level(lvl_i_p0, mod_p0);
    assign sym_q_p0 = scale_level(lvl_q_p0, mod_p0);
`else
    assign sym_i_p0 = scale_level(lvl_i_p0);
    assign sym_q_p0 = scale_level(lvl_q_p0);
`endif

    assign s_axis_tready = aresetn && (cnt_p0 <= 5'd8);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign load          = (cnt_p0 >= nbits_p0) && (!vld_p1 || m_axis_tready);

    // Consume first, then append the new byte just above the surviving bits.
    // Accept is only possible with cnt_p0 <= 8, so the byte always fits.
    always_comb begin
        cnt_left  = load ? (cnt_p0 - nbits_p0) : cnt_p0;
        bits_left = load ? (bits_p0 >> nbits_p0) : bits_p0;
        cnt_next  = cnt_left;
        bits_next = bits_left;
        if (accept) begin
            cnt_next  = cnt_left + 5'd8;
            bits_next = bits_left | ({8'd0, s_axis_tdata} << cnt_left);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bits_p0 <= '0;
            cnt_p0  <= '0;
            rate_p0 <= '0;
        end else begin
            bits_p0 <= bits_next;
            cnt_p0  <= cnt_next;
            if (accept && (cnt_p0 == 5'd0))
                rate_p0 <= s_axis_tuser;
        end
    end

    // ------------------------------------------------------------------
    // Stage p1: output register, held stable while the sink stalls
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            user_p1 <= '0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= {sym_q_p0, sym_i_p0};
            user_p1 <= rate_p0;
        end else if (m_axis_tready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign m_axis_tvalid = vld_p1;
    assign m_axis_tdata  = data_p1;
    assign m_axis_tuser  = user_p1;

endmodule
